// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a ROWS x COLS matrix keypad by driving one column at a time, then
// debounces press and release of a single key and reports its code.
//
// Operation summary
//   - The raw row lines pass through a two-flop synchroniser (rs_q). Every
//     decision is made on the synchronised value only.
//   - A divider paces the scan. A "sample" is the cycle in which the divider
//     sits at SCAN_DIV-1 while enable is high. The FSM acts only on samples.
//   - SCAN     : no row active -> advance to the next column. Exactly one row
//                active -> latch row/column and start debouncing on the held
//                column. Several rows active -> one-cycle multi_key strobe,
//                then advance.
//   - DEBOUNCE : the latched row pattern must be seen on DEBOUNCE consecutive
//                samples before the press is accepted. Any other value drops
//                back to SCAN without a strobe.
//   - HELD     : the latched row bit must read low on DEBOUNCE consecutive
//                samples before the key counts as released. Other row bits
//                are ignored, so a second key is never reported.
//
// Output strobe semantics: key_valid is a one-cycle, registered strobe with no
// backpressure. The consumer must take key_code in the cycle where key_valid
// is high. key_code then holds until the next accepted press; release never
// clears it. multi_key is an independent one-cycle strobe.
//
// enable=0 freezes divider, debounce counter, FSM, cols_out, key_code and
// key_down; key_valid and multi_key read 0. The synchroniser keeps running so
// it holds fresh data when scanning resumes.
//
// Ports
//   clk        in   1     system clock, rising edge
//   reset      in   1     asynchronous, active-low reset
//   enable     in   1     1 = run, 0 = freeze
//   rows_in    in   ROWS  raw row lines, active-high, asynchronous to clk
//   cols_out   out  COLS  one-hot column drive
//   key_valid  out  1     one-cycle strobe for an accepted press
//   key_code   out  KW    row*COLS+col of the last accepted key
//   key_down   out  1     high while an accepted key is held
//   multi_key  out  1     one-cycle strobe: several rows active at a sample
//   dbg_state  out  2     current FSM state (0=SCAN, 1=DEBOUNCE, 2=HELD)
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3,
  localparam int KW      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [ROWS-1:0] rows_in,
  output logic [COLS-1:0] cols_out,
  output logic            key_valid,
  output logic [KW-1:0]   key_code,
  output logic            key_down,
  output logic            multi_key,
  output logic [1:0]      dbg_state
);

  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW  = $clog2(DEBOUNCE + 1);
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = $clog2(COLS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0] rs_meta_q;
  logic [ROWS-1:0] rs_q;
  logic [DW-1:0]   div_q;
  logic [CW-1:0]   dcnt_q;
  state_e          state_q;
  logic [COLS-1:0] cols_q;
  logic [ROWS-1:0] row_pat_q;
  logic [RIW-1:0]  row_q;
  logic [CIW-1:0]  col_q;
  logic            key_valid_q;
  logic [KW-1:0]   key_code_q;
  logic            key_down_q;
  logic            multi_key_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   div_d;
  logic            sample;
  logic [COLS-1:0] cols_rot_d;
  logic [CW-1:0]   dcnt_inc_d;
  logic            dcnt_done;
  logic            rs_zero;
  logic            rs_onehot;
  logic [RIW-1:0]  row_idx_d;
  logic [CIW-1:0]  col_idx_d;

  function automatic logic [KW-1:0] code_of(input logic [RIW-1:0] r,
                                            input logic [CIW-1:0] c);
    return KW'(32'(r) * 32'(COLS) + 32'(c));
  endfunction

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
    end
  end

  assign sample     = enable && (div_q == DW'(SCAN_DIV - 1));
  assign cols_rot_d = {cols_q[COLS-2:0], cols_q[COLS-1]};
  assign dcnt_inc_d = dcnt_q + 1'b1;
  assign dcnt_done  = (dcnt_inc_d == CW'(DEBOUNCE));
  assign rs_zero    = (rs_q == '0);
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign rs_onehot  = !rs_zero && ((rs_q & (rs_q - 1'b1)) == '0);

  // Row index of the (one-hot) synchronised rows; only used when rs_onehot.
  always_comb begin
    row_idx_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (rs_q[i]) begin
        row_idx_d = RIW'(i);
      end
    end
  end

  // Column index of the currently driven column (cols_q is always one-hot).
  always_comb begin
    col_idx_d = '0;
    for (int i = 0; i < COLS; i++) begin
      if (cols_q[i]) begin
        col_idx_d = CIW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser: free-running, independent of enable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_meta_q <= '0;
      rs_q      <= '0;
    end else begin
      rs_meta_q <= rows_in;
      rs_q      <= rs_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-step divider
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (enable) begin
      div_q <= div_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan / debounce FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      dcnt_q      <= '0;
      cols_q      <= COLS'(1);
      row_pat_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_down_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      // Strobes default low every cycle, including while frozen.
      key_valid_q <= 1'b0;
      multi_key_q <= 1'b0;
      if (sample) begin
        unique case (state_q)
          ST_SCAN: begin
            if (rs_zero) begin
              cols_q <= cols_rot_d;
            end else if (rs_onehot) begin
              row_pat_q <= rs_q;
              row_q     <= row_idx_d;
              col_q     <= col_idx_d;
              if (DEBOUNCE == 1) begin
                // A single matching sample is already enough.
                key_valid_q <= 1'b1;
                key_code_q  <= code_of(row_idx_d, col_idx_d);
                key_down_q  <= 1'b1;
                dcnt_q      <= '0;
                state_q     <= ST_HELD;
              end else begin
                dcnt_q  <= CW'(1);
                state_q <= ST_DEBOUNCE;
              end
            end else begin
              multi_key_q <= 1'b1;
              cols_q      <= cols_rot_d;
            end
          end

          ST_DEBOUNCE: begin
            if (rs_q == row_pat_q) begin
              if (dcnt_done) begin
                key_valid_q <= 1'b1;
                key_code_q  <= code_of(row_q, col_q);
                key_down_q  <= 1'b1;
                dcnt_q      <= '0;
                state_q     <= ST_HELD;
              end else begin
                dcnt_q <= dcnt_inc_d;
              end
            end else begin
              // Bounce or a second key: abandon this column without a strobe.
              dcnt_q  <= '0;
              cols_q  <= cols_rot_d;
              state_q <= ST_SCAN;
            end
          end

          ST_HELD: begin
            // Only the latched row matters; any re-assertion restarts the
            // release count.
            if ((rs_q & row_pat_q) == '0) begin
              if (dcnt_done) begin
                key_down_q <= 1'b0;
                dcnt_q     <= '0;
                cols_q     <= cols_rot_d;
                state_q    <= ST_SCAN;
              end else begin
                dcnt_q <= dcnt_inc_d;
              end
            end else begin
              dcnt_q <= '0;
            end
          end

          default: begin
            dcnt_q  <= '0;
            state_q <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign cols_out  = cols_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;
  assign multi_key = multi_key_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner. Two instances share one clock:
//   u_dut   : default parameters (4x4, SCAN_DIV=4, DEBOUNCE=3)
//   u_small : COLS=3, ROWS=4, SCAN_DIV=1, DEBOUNCE=1
// Inputs are driven and outputs observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_down;
  logic       multi_key;
  logic [1:0] dbg_state;

  logic       reset2, enable2;
  logic [3:0] rows2;
  logic [2:0] cols2;
  logic       kv2;
  logic [3:0] kc2;
  logic       kd2;
  logic       mk2;
  logic [1:0] st2;

  keypad_scanner u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rows_in   (rows_in),
    .cols_out  (cols_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .multi_key (multi_key),
    .dbg_state (dbg_state)
  );

  keypad_scanner #(
    .COLS     (3),
    .ROWS     (4),
    .SCAN_DIV (1),
    .DEBOUNCE (1)
  ) u_small (
    .clk       (clk),
    .reset     (reset2),
    .enable    (enable2),
    .rows_in   (rows2),
    .cols_out  (cols2),
    .key_valid (kv2),
    .key_code  (kc2),
    .key_down  (kd2),
    .multi_key (mk2),
    .dbg_state (st2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and monitors
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int kv_cnt   = 0;  // key_valid pulses seen on u_dut
  int mk_cnt   = 0;  // multi_key pulses seen on u_dut
  int en_cnt   = 0;  // enabled cycles since reset release -> divider phase

  always @(posedge clk) begin
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (multi_key) mk_cnt <= mk_cnt + 1;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset)      en_cnt <= 0;
    else if (enable) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until 'col' is driven and the divider is two cycles before its
  // sample, then apply the row pattern.
  task automatic arm(input logic [3:0] col, input logic [3:0] rows);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (cols_out == col && (en_cnt % 4) == 1) found = 1'b1;
    end
    if (found) rows_in = rows;
    else       check("arm_timeout", 32'd0, 32'd1);
  endtask

  // Cycles until key_valid rises (0 if it never does within the budget).
  task automatic wait_kv(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 60 && !found; i++) begin
      @(negedge clk);
      if (key_valid) begin
        found = 1'b1;
        n = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    reset   = 1'b0; enable  = 1'b0; rows_in = '0;
    reset2  = 1'b0; enable2 = 1'b0; rows2   = '0;
    tick(3);

    // Reset state
    check("rst_cols",      cols_out,  32'd1);
    check("rst_key_valid", key_valid, 32'd0);
    check("rst_key_code",  key_code,  32'd0);
    check("rst_key_down",  key_down,  32'd0);
    check("rst_multi_key", multi_key, 32'd0);
    check("rst_state",     dbg_state, 32'd0);
    check("rst_small_cols", cols2,    32'd1);

    // Idle scan: one column step every 4 cycles, with wrap
    reset = 1'b1; enable = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      check("scan_cols", cols_out, 32'(1) << ((i / 4) % 4));
      if (i < 16) tick(1);
    end
    check("scan_no_kv",   kv_cnt,   32'd0);
    check("scan_no_mk",   mk_cnt,   32'd0);
    check("scan_code",    key_code, 32'd0);

    // Stable press at row2/col1 -> code 9, 9-cycle latency
    arm(4'b0010, 4'b0100);
    tick(2);
    wait_kv(lat);
    check("press_latency", lat,       32'd9);
    check("press_code",    key_code,  32'd9);
    check("press_down",    key_down,  32'd1);
    check("press_cols",    cols_out,  32'b0010);
    check("press_state",   dbg_state, 32'd2);
    tick(1);
    check("press_strobe_1cyc", key_valid, 32'd0);
    rows_in = 4'b0000;
    tick(10);
    check("rel_down_still", key_down, 32'd1);
    check("rel_cols_held",  cols_out, 32'b0010);
    tick(1);
    check("rel_down",     key_down, 32'd0);
    check("rel_cols",     cols_out, 32'b0100);
    check("rel_code_kept", key_code, 32'd9);
    check("rel_one_kv",   kv_cnt,   32'd1);

    // Bounce at col0: one matching sample only
    arm(4'b0001, 4'b0001);
    tick(4);
    check("bounce_cols_held", cols_out,  32'b0001);
    check("bounce_state_db",  dbg_state, 32'd1);
    rows_in = 4'b0000;
    tick(3);
    check("bounce_cols",  cols_out,  32'b0010);
    check("bounce_state", dbg_state, 32'd0);
    check("bounce_no_kv", kv_cnt,    32'd1);

    // Same key pressed stably -> code 0
    arm(4'b0001, 4'b0001);
    tick(2);
    wait_kv(lat);
    check("repress_latency", lat,      32'd9);
    check("repress_code",    key_code, 32'd0);
    tick(1);
    rows_in = 4'b0000;
    tick(11);
    check("repress_rel_down", key_down, 32'd0);
    check("repress_rel_cols", cols_out, 32'b0010);
    check("repress_kv_cnt",   kv_cnt,   32'd2);

    // Two rows at once -> multi_key strobe, scan advances
    arm(4'b0100, 4'b0011);
    tick(2);
    check("multi_pre", multi_key, 32'd0);
    tick(1);
    check("multi_pulse", multi_key, 32'd1);
    check("multi_cols",  cols_out,  32'b1000);
    check("multi_no_kv", key_valid, 32'd0);
    rows_in = 4'b0000;
    tick(1);
    check("multi_1cyc", multi_key, 32'd0);
    check("multi_cnt",  mk_cnt,    32'd1);

    // Freeze for 20 cycles in DEBOUNCE, then complete the press (row2/col3)
    arm(4'b1000, 4'b0100);
    tick(4);
    enable = 1'b0;
    check("frz_state_in", dbg_state, 32'd1);
    tick(20);
    check("frz_cols",  cols_out,  32'b1000);
    check("frz_state", dbg_state, 32'd1);
    check("frz_no_kv", kv_cnt,    32'd2);
    enable = 1'b1;
    wait_kv(lat);
    check("frz_latency", lat,      32'd7);
    check("frz_code",    key_code, 32'd11);
    check("frz_down",    key_down, 32'd1);

    // Reset while HELD
    tick(3);
    reset   = 1'b0;
    rows_in = 4'b0000;
    #1;
    check("held_rst_cols",  cols_out,  32'd1);
    check("held_rst_down",  key_down,  32'd0);
    check("held_rst_code",  key_code,  32'd0);
    check("held_rst_kv",    key_valid, 32'd0);
    check("held_rst_state", dbg_state, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(12);
    check("post_rst_no_kv", kv_cnt,   32'd3);
    check("post_rst_cols",  cols_out, 32'b1000);
    check("post_rst_down",  key_down, 32'd0);

    // Small instance: 3 columns, every cycle a sample, no debounce wait
    reset2 = 1'b1; enable2 = 1'b1;
    check("sm_cols0", cols2, 32'b001);
    tick(1); check("sm_cols1", cols2, 32'b010);
    tick(1); check("sm_cols2", cols2, 32'b100);
    tick(1); check("sm_wrap",  cols2, 32'b001);
    rows2 = 4'b1000;
    tick(1); check("sm_cols_a", cols2, 32'b010);
    tick(1); check("sm_cols_b", cols2, 32'b100);
    check("sm_kv_pre", kv2, 32'd0);
    tick(1);
    check("sm_kv",      kv2,   32'd1);
    check("sm_code",    kc2,   32'd11);
    check("sm_down",    kd2,   32'd1);
    check("sm_cols_hd", cols2, 32'b100);
    rows2 = 4'b0000;
    tick(1); check("sm_kv_1cyc", kv2, 32'd0);
    tick(1); check("sm_still_down", kd2, 32'd1);
    tick(1);
    check("sm_rel_down", kd2,   32'd0);
    check("sm_rel_wrap", cols2, 32'b001);
    check("sm_rel_code", kc2,   32'd11);
    check("sm_no_multi", mk2,   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
